temporal_avg_pool: RTL
======================

# temporal_avg_pool

Streaming temporal average-pooling stage that consumes the fixed-point sample stream produced by the temporal convolution stage (`data` + `valid`, no backpressure). It sums non-overlapping windows of `POOL_SIZE` consecutive valid samples and emits one averaged sample per window. It tracks a frame of `FRAME_LEN` input samples, flags the last pooled output of each frame, and discards the frame tail that does not fill a complete window. It sits between the temporal convolution and the downstream depthwise/spatial stages.

## Interface
- `DATA_WIDTH`, 16: width of signed input and output samples.
- `POOL_SIZE`, 8: window length and stride. Must be a power of two, ≥ 2.
- `FRAME_LEN`, 64: input samples per frame. Must be ≥ `POOL_SIZE`. Need not be a multiple of `POOL_SIZE`.
- Derived: `SHIFT` = log2(`POOL_SIZE`); `NUM_WIN` = floor(`FRAME_LEN` / `POOL_SIZE`); `ACC_WIDTH` = `DATA_WIDTH` + `SHIFT`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x_in`  in  `DATA_WIDTH` signed  input sample; qualified by `x_valid`.
- `x_valid`  in  1  input sample valid; no ready, every valid sample must be consumed.
- `sync_clr`  in  1  synchronous realign: clears counters and accumulator.
- `p_out`  out  `DATA_WIDTH` signed  pooled sample.
- `p_valid`  out  1  one-cycle pulse qualifying `p_out`.
- `p_last`  out  1  high with `p_valid` on the final window (`NUM_WIN`-1) of a frame.
- `frame_done`  out  1  one-cycle pulse after sample index `FRAME_LEN`-1 is consumed.

## Operation
- State:
  - `acc` (`ACC_WIDTH` signed)
  - `win_cnt` (0..`POOL_SIZE`-1): position within the current window
  - `win_idx` (0..`NUM_WIN`): window number within the frame
  - `samp_cnt` (0..`FRAME_LEN`-1): sample index within the frame
- Phases, derived from counters:
  - POOL: `win_idx` < `NUM_WIN`.
  - TAIL: `win_idx` == `NUM_WIN`. Samples are counted but not accumulated.
- Accepted sample in POOL:
  - `win_cnt` == 0: `acc` <= sign-extended `x_in`.
  - Otherwise: `acc` <= `acc` + `x_in`.
  - `win_cnt` increments.
- Window close (POOL and `win_cnt` == `POOL_SIZE`-1):
  - `p_out` <= (`acc` + `x_in`) >>> `SHIFT`. Arithmetic shift, i.e. floor toward −inf, no rounding.
  - `p_valid` <= 1.
  - `p_last` <= (`win_idx` == `NUM_WIN`-1).
  - `win_cnt` <= 0; `win_idx` increments.
- Sum never overflows `ACC_WIDTH`, so the result always fits `DATA_WIDTH`; no saturation logic.
- Accepted sample in TAIL: only `samp_cnt` advances. `acc` and `p_out` are unchanged.
- Frame wrap: an accepted sample with `samp_cnt` == `FRAME_LEN`-1 sets `samp_cnt`, `win_cnt`, `win_idx` <= 0 and `frame_done` <= 1. This also covers the case where that sample closes the last window (no tail).
- `x_valid` low: all state holds; a gap of any length inside a window is legal.
- `sync_clr` high:
  - Counters and `acc` <= 0.
  - `p_valid`, `p_last`, `frame_done` <= 0.
  - `p_out` holds.
  - Overrides a simultaneous `x_valid`; that sample is discarded.
- Reset, asynchronous: `p_out` = 0, `p_valid` = 0, `p_last` = 0, `frame_done` = 0, and all counters and `acc` = 0. Assertion mid-window abandons the partial window with no output.

## Timing
- Latency: `p_valid` is high the cycle after the clock edge that accepts the window-closing sample (1 cycle).
- `p_out` holds its value until the next window closes; downstream samples it only with `p_valid`.
- `frame_done` rises on the same edge as the final `p_valid` when `FRAME_LEN` is a multiple of `POOL_SIZE`. Otherwise it rises after the last tail sample.
- `p_valid`, `p_last`, `frame_done` are single-cycle pulses, even under back-to-back `x_valid`.
- Throughput: one sample per cycle sustained. Output rate is 1/`POOL_SIZE`.
- `rst_n` deassertion is synchronized externally; the first accepted sample may arrive on the first active edge.

## Test plan
- `POOL_SIZE`=4, `FRAME_LEN`=10, continuous valid, `x` = 1..10:
  - `p_out`=2 (sum 10), then `p_out`=6 (sum 26) with `p_last`=1.
  - Samples 9 and 10 produce no output.
  - `frame_done` pulses once after sample 10.
  - Next frame restarts at window 0.
- Negative flooring: `x` = -1, -2, -2, -2 (sum -7) -> `p_out`=-2, not -1.
- Extremes:
  - Four × 32767 -> `p_out`=32767.
  - Four × -32768 -> `p_out`=-32768.
  - No wrap in either case.
- Gappy input: ramp 1..8 with random 0-5 cycle `x_valid` gaps -> same outputs (2, 6) as the continuous case. Each `p_valid` is exactly 1 cycle after the 4th/8th accepted sample.
- `sync_clr` with `x_valid` after 2 samples of a window -> that sample is dropped, no `p_valid`. The next 4 samples 4,4,4,4 give `p_out`=4 as window 0.
- `rst_n` low mid-window, then release:
  - All outputs read 0 during reset.
  - The first complete window after release is averaged alone, with no contribution from pre-reset samples.

Source files
------------

// File: rtl/temporal_avg_pool_if.sv
// Sample stream into the temporal average pool and pooled stream out of it.
// The master drives samples; the slave (the pooling stage) drives pooled results.
interface temporal_avg_pool_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_valid;
  logic                         sync_clr;
  logic signed [DATA_WIDTH-1:0] p_out;
  logic                         p_valid;
  logic                         p_last;
  logic                         frame_done;

  modport master (
    output x_in, x_valid, sync_clr,
    input  p_out, p_valid, p_last, frame_done
  );

  modport slave (
    input  x_in, x_valid, sync_clr,
    output p_out, p_valid, p_last, frame_done
  );
endinterface

// File: rtl/temporal_avg_pool.sv
// Non-overlapping temporal average pooling over POOL_SIZE samples, framed by
// FRAME_LEN input samples; the incomplete tail window of each frame is dropped.
module temporal_avg_pool #(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_SIZE  = 8,
  parameter int FRAME_LEN  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  temporal_avg_pool_if.slave pif
);
  localparam int SHIFT     = $clog2(POOL_SIZE);
  localparam int NUM_WIN   = FRAME_LEN / POOL_SIZE;
  localparam int ACC_WIDTH = DATA_WIDTH + SHIFT;
  localparam int IDX_W     = $clog2(NUM_WIN + 1);
  localparam int SAMP_W    = $clog2(FRAME_LEN);

  localparam logic [SHIFT-1:0]  WIN_LAST  = SHIFT'(POOL_SIZE - 1);
  localparam logic [IDX_W-1:0]  IDX_TAIL  = IDX_W'(NUM_WIN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WIN - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(FRAME_LEN - 1);

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  x_ext_p0;
  logic signed [ACC_WIDTH-1:0]  sum_p0;
  logic [SHIFT-1:0]             win_cnt;
  logic [IDX_W-1:0]             win_idx;
  logic [SAMP_W-1:0]            samp_cnt;
  logic                         in_pool_p0;
  logic                         win_close_p0;

  logic signed [DATA_WIDTH-1:0] out_p1;
  logic                         vld_p1;
  logic                         last_p1;
  logic                         done_p1;

  // Floor average: arithmetic shift rounds toward -inf; the sum of POOL_SIZE
  // in-range samples always fits ACC_WIDTH, so the quotient fits DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] avg_floor(
    input logic signed [ACC_WIDTH-1:0] s
  );
    return DATA_WIDTH'(s >>> SHIFT);
  endfunction

  // Stage p0: combinational sum of the running window and the incoming sample
  assign x_ext_p0     = {{SHIFT{pif.x_in[DATA_WIDTH-1]}}, pif.x_in};
  assign sum_p0       = acc + x_ext_p0;
  assign in_pool_p0   = (win_idx < IDX_TAIL);
  assign win_close_p0 = in_pool_p0 && (win_cnt == WIN_LAST);

  // Stage p1: registered counters, accumulator and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      win_cnt  <= '0;
      win_idx  <= '0;
      samp_cnt <= '0;
      out_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else if (pif.sync_clr) begin
      acc      <= '0;
      win_cnt  <= '0;
      win_idx  <= '0;
      samp_cnt <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
      if (pif.x_valid) begin
        if (in_pool_p0) begin
          acc <= (win_cnt == '0) ? x_ext_p0 : sum_p0;
          if (win_close_p0) begin
            out_p1  <= avg_floor(sum_p0);
            vld_p1  <= 1'b1;
            last_p1 <= (win_idx == IDX_LAST);
            win_cnt <= '0;
            win_idx <= win_idx + 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        // Frame wrap takes priority over the window bookkeeping above.
        if (samp_cnt == SAMP_LAST) begin
          samp_cnt <= '0;
          win_cnt  <= '0;
          win_idx  <= '0;
          done_p1  <= 1'b1;
        end else begin
          samp_cnt <= samp_cnt + 1'b1;
        end
      end
    end
  end

  assign pif.p_out      = out_p1;
  assign pif.p_valid    = vld_p1;
  assign pif.p_last     = last_p1;
  assign pif.frame_done = done_p1;

endmodule
